// File: rtl/usb4_tc_noc_fifo_buf_ctrl_8_25.sv
// usb4_tc_noc_fifo_buf_ctrl_8_25: pointer/occupancy/handshake controller for an 8x25 link FIFO over an external async-read two-port RAM.
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   in_valid_i/in_ready_o      producer handshake (in_ready_o registered)
//   in_data_i                  producer payload
//   out_valid_o/out_ready_i    consumer handshake
//   out_data_o                 head payload, 0 while out_valid_o is low
//   ram_wen_o/waddr_o/wdata_o  RAM write port (synchronous write)
//   ram_ren_o/raddr_o          RAM read port
//   ram_rdata_i                RAM asynchronous read data
//   level_o                    words held (RAM plus output stage)
//   ovf_err_o                  sticky: producer stalled on a full FIFO for more than 255 cycles
// Build option: USB4_TC_NOC_FIFO_BUF_CTRL_OUTREG_EN adds a one-entry registered output stage.
module usb4_tc_noc_fifo_buf_ctrl_8_25 #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 25,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             ram_wen_o,
    output logic [AW-1:0]    ram_waddr_o,
    output logic [WIDTH-1:0] ram_wdata_o,
    output logic             ram_ren_o,
    output logic [AW-1:0]    ram_raddr_o,
    input  logic [WIDTH-1:0] ram_rdata_i,
    output logic [AW:0]      level_o,
    output logic             ovf_err_o
);
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt, total, total_d;
    logic        in_ready_q, in_ready_d, ovf_q, ovf_d, stall;
    logic [7:0]  stall_q, stall_d;
    logic        push, pop_out, pop_ram, ram_empty;
    // Wrap bit makes full (addresses equal, wrap differs) distinct from empty.
    assign ram_cnt   = wr_ptr_q - rd_ptr_q;
    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign push      = in_valid_i & in_ready_q;
`ifdef USB4_TC_NOC_FIFO_BUF_CTRL_OUTREG_EN
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH + 1);
    logic             obuf_vld_q, obuf_vld_d;
    logic [WIDTH-1:0] obuf_data_q, obuf_data_d;
    // Prefetch whenever the stage is empty or being drained this cycle.
    assign pop_out     = obuf_vld_q & out_ready_i;
    assign pop_ram     = !ram_empty & (!obuf_vld_q | out_ready_i);
    assign total       = ram_cnt + {{AW{1'b0}}, obuf_vld_q};
    assign out_valid_o = obuf_vld_q;
    assign out_data_o  = obuf_vld_q ? obuf_data_q : '0;
    always_comb begin
        obuf_vld_d  = pop_ram | (obuf_vld_q & !pop_out);
        obuf_data_d = pop_ram ? ram_rdata_i : obuf_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_vld_q  <= 1'b0;
            obuf_data_q <= '0;
        end else begin
            obuf_vld_q  <= obuf_vld_d;
            obuf_data_q <= obuf_data_d;
        end
    end
`else
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
    assign pop_out     = !ram_empty & out_ready_i;
    assign pop_ram     = pop_out;
    assign total       = ram_cnt;
    assign out_valid_o = !ram_empty;
    assign out_data_o  = ram_empty ? '0 : ram_rdata_i;
`endif
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_ram};
        total_d    = total + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_out};
        // No bypass: ready is decided from the post-edge occupancy only.
        in_ready_d = total_d < CAP;
        stall      = in_valid_i & !in_ready_q;
        stall_d    = !stall ? 8'd0 : (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
        ovf_d      = ovf_q | (stall & (stall_q == 8'hFF));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
            ovf_q      <= ovf_d;
        end
    end
    assign in_ready_o  = in_ready_q;
    assign ram_wen_o   = push;
    assign ram_waddr_o = wr_ptr_q[AW-1:0];
    assign ram_wdata_o = in_data_i;
    assign ram_ren_o   = !ram_empty;
    assign ram_raddr_o = rd_ptr_q[AW-1:0];
    assign level_o     = total;
    assign ovf_err_o   = ovf_q;
endmodule

// File: tb/tb_usb4_tc_noc_fifo_buf_ctrl_8_25.sv
// tb_usb4_tc_noc_fifo_buf_ctrl_8_25: directed bench for the link FIFO controller with a behavioural async-read RAM.
module tb_usb4_tc_noc_fifo_buf_ctrl_8_25;
`ifdef USB4_TC_NOC_FIFO_BUF_CTRL_OUTREG_EN
    localparam int CAP = 9;
    localparam int LAT = 2;
`else
    localparam int CAP = 8;
    localparam int LAT = 1;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [24:0] in_data = '0;
    logic        in_ready, out_valid, ram_wen, ram_ren, ovf_err;
    logic [24:0] out_data, ram_wdata, ram_rdata;
    logic [2:0]  ram_waddr, ram_raddr;
    logic [3:0]  level;
    logic [24:0] mem [8];
    logic [24:0] q [$];
    int n_vec = 0, n_err = 0, wraps = 0;
    always #5 clk = ~clk;
    always_ff @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = mem[ram_raddr];
    usb4_tc_noc_fifo_buf_ctrl_8_25 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .ram_wen_o(ram_wen), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .ram_ren_o(ram_ren), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
        .level_o(level), .ovf_err_o(ovf_err)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic chk_reset();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_ram_wen", 32'(ram_wen), 0);
        chk("rst_ram_ren", 32'(ram_ren), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
        chk("rst_raddr", 32'(ram_raddr), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
    endtask
    // One clock: score handshakes just before the edge, then check occupancy after it.
    task automatic cycle();
        logic p, o;
        logic [24:0] d;
        #1;
        p = in_valid & in_ready;
        o = out_valid & out_ready;
        d = out_data;
        if (p) begin
            chk("ram_wen", 32'(ram_wen), 1);
            chk("ram_wdata", 32'(ram_wdata), 32'(in_data));
            if (ram_waddr == 3'd7) wraps++;
        end
        if (o) begin
            chk("pop_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("pop_data", 32'(d), 32'(q.pop_front()));
        end
        if (p) q.push_back(in_data);
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < CAP));
    endtask
    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        chk("drain_level", 32'(level), 0);
        chk("drain_out_valid", 32'(out_valid), 0);
        out_ready = 1'b0;
    endtask
    initial begin
        int n, maxlvl;
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        #3 rst_n = 1'b1;
        #1 chk("pre_edge_in_ready", 32'(in_ready), 0);
        cycle();
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_data", 32'(out_data), 0);
        // Single word
        in_valid = 1'b1;
        in_data = 25'h1ABCDEF;
        cycle();
        in_valid = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            chk("single_not_yet", 32'(out_valid), 0);
            cycle();
        end
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", 32'(out_data), 32'h1ABCDEF);
        chk("single_level", 32'(level), 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("single_pop_valid", 32'(out_valid), 0);
        chk("single_pop_level", 32'(level), 0);
        // Fill to capacity, then drain in order
        in_valid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            in_data = 25'(i);
            cycle();
        end
        in_valid = 1'b0;
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_level", 32'(level), CAP);
        chk("fill_head", 32'(out_data), 0);
        out_ready = 1'b1;
        cycle();
        chk("fill_ready_back", 32'(in_ready), 1);
        drain();
        // Streaming with wrap-around
        wraps = 0;
        maxlvl = 0;
        n = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && n < 40; i++) begin
            in_data = 25'(32'h1000 + n);
            if (in_ready) n++;
            cycle();
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        chk("stream_count", n, 40);
        chk("stream_wraps", wraps, 5);
        chk("stream_maxlvl_le2", 32'(maxlvl <= 2), 1);
        drain();
        // Simultaneous push and pop at level 4
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 25'(32'h200 + i);
            cycle();
        end
        chk("sim_level4", 32'(level), 4);
        chk("sim_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 25'(32'h300 + i);
            cycle();
            chk("sim_level_hold", 32'(level), 4);
        end
        drain();
        // Random traffic against the scoreboard
        n = 0;
        for (int i = 0; i < 20000 && n < 1000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 25'($urandom());
            out_ready = $urandom_range(0, 1) == 1;
            if (in_valid && in_ready) n++;
            cycle();
        end
        chk("rand_count", n, 1000);
        drain();
        // Overflow stall
        in_valid = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            in_data = 25'(32'h400 + i);
            cycle();
        end
        repeat (100) cycle();
        chk("stall_ovf_early", 32'(ovf_err), 0);
        repeat (200) cycle();
        chk("stall_ovf_set", 32'(ovf_err), 1);
        drain();
        chk("stall_ovf_sticky", 32'(ovf_err), 1);
        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 25'(32'h500 + i);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        chk_reset();
        q.delete();
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        cycle();
        chk("rerst_in_ready", 32'(in_ready), 1);
        chk("rerst_ovf", 32'(ovf_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
